// File: rtl/axi_sram_ctrl_if.sv
// AXI4 bus bundle between an AXI master and axi_sram_ctrl.
// Signal widths follow the AXI_* defines (IDS, ADDR, LEN, SIZE, DATA, STRB).
`ifndef AXI_IDS
`define AXI_IDS 8
`endif
`ifndef AXI_ADDR
`define AXI_ADDR 32
`endif
`ifndef AXI_LEN
`define AXI_LEN 4
`endif
`ifndef AXI_SIZE
`define AXI_SIZE 3
`endif
`ifndef AXI_DATA
`define AXI_DATA 32
`endif
`ifndef AXI_STRB
`define AXI_STRB 4
`endif

interface axi_sram_ctrl_if;
    logic [`AXI_IDS-1:0]  AWID;
    logic [`AXI_ADDR-1:0] AWADDR;
    logic [`AXI_LEN-1:0]  AWLEN;
    logic [`AXI_SIZE-1:0] AWSIZE;
    logic [1:0]           AWBURST;
    logic                 AWVALID;
    logic                 AWREADY;

    logic [`AXI_DATA-1:0] WDATA;
    logic [`AXI_STRB-1:0] WSTRB;
    logic                 WLAST;
    logic                 WVALID;
    logic                 WREADY;

    logic [`AXI_IDS-1:0]  BID;
    logic [1:0]           BRESP;
    logic                 BVALID;
    logic                 BREADY;

    logic [`AXI_IDS-1:0]  ARID;
    logic [`AXI_ADDR-1:0] ARADDR;
    logic [`AXI_LEN-1:0]  ARLEN;
    logic [`AXI_SIZE-1:0] ARSIZE;
    logic [1:0]           ARBURST;
    logic                 ARVALID;
    logic                 ARREADY;

    logic [`AXI_IDS-1:0]  RID;
    logic [`AXI_DATA-1:0] RDATA;
    logic [1:0]           RRESP;
    logic                 RLAST;
    logic                 RVALID;
    logic                 RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_sram_ctrl.sv
// Single-transaction AXI4 slave in front of a synchronous 32-bit SRAM (DO valid one cycle after access).
// Define AXI_SRAM_WRAP_EN to support WRAP bursts; otherwise WRAP is answered with SLVERR.
`ifndef AXI_IDS
`define AXI_IDS 8
`endif
`ifndef AXI_ADDR
`define AXI_ADDR 32
`endif
`ifndef AXI_LEN
`define AXI_LEN 4
`endif
`ifndef AXI_SIZE
`define AXI_SIZE 3
`endif
`ifndef AXI_DATA
`define AXI_DATA 32
`endif
`ifndef AXI_STRB
`define AXI_STRB 4
`endif

module axi_sram_ctrl #(
    parameter int unsigned SRAM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    axi_sram_ctrl_if.slave      axi,
    output logic                CEB,
    output logic [3:0]          WEB,
    output logic [SRAM_AW-1:0]  A,
    output logic [31:0]         DI,
    input  logic [31:0]         DO
);
    localparam int unsigned LW = `AXI_LEN;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_ISSUE,
        RD_DATA
    } state_t;

    state_t                 state, state_nxt;
    logic                   prefer_rd;
    logic [`AXI_IDS-1:0]    id_q;
    logic [LW-1:0]          len_q;
    logic [LW-1:0]          cnt_q;
    logic [1:0]             burst_q;
    logic [SRAM_AW-1:0]     addr_q;
    logic [SRAM_AW-1:0]     addr_nxt;
    logic [SRAM_AW-1:0]     addr_inc;
    logic [SRAM_AW-1:0]     len_mask;
    logic                   err_q;
    logic                   fresh_q;
    logic [31:0]            rdata_q;
    logic [31:0]            rd_word;
    logic                   wr_grant;
    logic                   rd_grant;
    logic                   last_beat;
    logic                   unsup;
    logic                   unused_bits;

    assign unused_bits = ^{axi.AWSIZE, axi.ARSIZE, axi.AWADDR, axi.ARADDR};

`ifdef AXI_SRAM_WRAP_EN
    assign unsup = 1'b0;
`else
    assign unsup = (burst_q == BURST_WRAP);
`endif

    // Ties go to whichever direction was not served last; after reset that is write.
    assign wr_grant  = axi.AWVALID && (!axi.ARVALID || !prefer_rd);
    assign rd_grant  = axi.ARVALID && (!axi.AWVALID || prefer_rd);
    assign last_beat = (cnt_q == len_q);

    assign addr_inc = addr_q + SRAM_AW'(1);
    assign len_mask = SRAM_AW'(len_q);

    always_comb begin
        addr_nxt = addr_inc;
        case (burst_q)
            BURST_FIXED: addr_nxt = addr_q;
`ifdef AXI_SRAM_WRAP_EN
            // LEN+1 is a power of two, so LEN itself is the in-block offset mask.
            BURST_WRAP:  addr_nxt = (addr_q & ~len_mask) | (addr_inc & len_mask);
`endif
            default:     addr_nxt = addr_inc;
        endcase
    end

    assign rd_word = unsup ? '0 : DO;

    always_comb begin
        state_nxt   = state;
        axi.AWREADY = 1'b0;
        axi.ARREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.RVALID  = 1'b0;
        CEB         = 1'b1;
        WEB         = '1;
        A           = '0;
        DI          = '0;
        case (state)
            IDLE: begin
                axi.AWREADY = wr_grant;
                axi.ARREADY = rd_grant;
                if (wr_grant) begin
                    state_nxt = WR_DATA;
                end else if (rd_grant) begin
                    state_nxt = RD_ISSUE;
                end
            end
            WR_DATA: begin
                axi.WREADY = 1'b1;
                if (axi.WVALID) begin
                    if (!unsup) begin
                        CEB = 1'b0;
                        WEB = ~axi.WSTRB;
                        A   = addr_q;
                        DI  = axi.WDATA;
                    end
                    if (last_beat) begin
                        state_nxt = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                axi.BVALID = 1'b1;
                if (axi.BREADY) begin
                    state_nxt = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!unsup) begin
                    CEB = 1'b0;
                    A   = addr_q;
                end
                state_nxt = RD_DATA;
            end
            RD_DATA: begin
                axi.RVALID = 1'b1;
                if (axi.RREADY) begin
                    state_nxt = last_beat ? IDLE : RD_ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign axi.BID   = id_q;
    assign axi.BRESP = err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi.RID   = id_q;
    assign axi.RRESP = ((state == RD_DATA) && unsup) ? RESP_SLVERR : RESP_OKAY;
    assign axi.RLAST = (state == RD_DATA) && last_beat;
    // DO is only valid in the first RD_DATA cycle; it is passed straight through
    // then and held from rdata_q while the master stalls.
    assign axi.RDATA = ((state == RD_DATA) && fresh_q) ? rd_word : rdata_q;

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            prefer_rd <= 1'b0;
            id_q      <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            burst_q   <= '0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            fresh_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (wr_grant) begin
                        id_q      <= axi.AWID;
                        len_q     <= axi.AWLEN;
                        burst_q   <= axi.AWBURST;
                        addr_q    <= axi.AWADDR[SRAM_AW+1:2];
                        prefer_rd <= 1'b1;
                    end else if (rd_grant) begin
                        id_q      <= axi.ARID;
                        len_q     <= axi.ARLEN;
                        burst_q   <= axi.ARBURST;
                        addr_q    <= axi.ARADDR[SRAM_AW+1:2];
                        prefer_rd <= 1'b0;
                    end
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    fresh_q <= 1'b0;
                end
                WR_DATA: begin
                    if (axi.WVALID) begin
                        if (unsup || (axi.WLAST != last_beat)) begin
                            err_q <= 1'b1;
                        end
                        if (!last_beat) begin
                            cnt_q  <= cnt_q + LW'(1);
                            addr_q <= addr_nxt;
                        end
                    end
                end
                RD_ISSUE: begin
                    fresh_q <= 1'b1;
                end
                RD_DATA: begin
                    fresh_q <= 1'b0;
                    if (fresh_q) begin
                        rdata_q <= rd_word;
                    end
                    if (axi.RREADY && !last_beat) begin
                        cnt_q  <= cnt_q + LW'(1);
                        addr_q <= addr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Directed bench for axi_sram_ctrl: vector table of AXI transactions plus arbitration and reset sequences.
`timescale 1ns/1ps
module tb_axi_sram_ctrl;
    localparam int unsigned SRAM_AW = 14;
    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;
    localparam int NV = 16;

    typedef struct packed {
        logic             wr;
        logic [7:0]       id;
        logic [31:0]      addr;
        logic [3:0]       len;
        logic [1:0]       burst;
        logic [3:0]       strb;
        logic [3:0]       bad;   // beat whose WLAST is inverted, 4'hF = none
        logic [3:0][31:0] d;     // write data or expected read data per beat
        logic [1:0]       resp;
        logic             acc;   // write beats expected to reach the SRAM
        logic [13:0]      a0;    // expected SRAM word address of beat 0
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ceb;
    logic [3:0] web;
    logic [SRAM_AW-1:0] a;
    logic [31:0] di;
    logic [31:0] sram_do = '0;
    logic [31:0] mem [0:(1<<SRAM_AW)-1];
    int n_applied = 0;
    int n_miss = 0;
    vec_t vecs [NV];

    axi_sram_ctrl_if bus ();

    axi_sram_ctrl #(.SRAM_AW(SRAM_AW)) dut (
        .ACLK(clk), .ARESETn(rst_n), .axi(bus),
        .CEB(ceb), .WEB(web), .A(a), .DI(di), .DO(sram_do)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] we_n);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (!we_n[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!ceb) begin
            if (web != 4'hF) mem[a] <= merge(mem[a], di, web);
            sram_do <= mem[a];
        end
    end

    function automatic vec_t mk(input logic wr, input logic [7:0] id, input logic [31:0] addr,
                                input logic [3:0] len, input logic [1:0] burst, input logic [3:0] strb,
                                input logic [3:0] bad, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3, input logic [1:0] resp,
                                input logic acc, input logic [13:0] a0);
        vec_t v;
        v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.burst = burst; v.strb = strb;
        v.bad = bad; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.resp = resp; v.acc = acc; v.a0 = a0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic timed_out(input string name);
        n_applied++;
        n_miss++;
        $display("FAIL %s: no handshake within 50 cycles, expected one", name);
    endtask

    task automatic aw_phase(input vec_t v);
        int k;
        k = 0;
        bus.AWID = v.id; bus.AWADDR = v.addr; bus.AWLEN = v.len;
        bus.AWSIZE = 3'd2; bus.AWBURST = v.burst; bus.AWVALID = 1'b1;
        #1;
        while (!bus.AWREADY && k < 50) begin @(negedge clk); #1; k++; end
        if (k == 50) timed_out("awready");
        @(negedge clk);
        bus.AWVALID = 1'b0;
    endtask

    task automatic ar_phase(input vec_t v);
        int k;
        k = 0;
        bus.ARID = v.id; bus.ARADDR = v.addr; bus.ARLEN = v.len;
        bus.ARSIZE = 3'd2; bus.ARBURST = v.burst; bus.ARVALID = 1'b1;
        #1;
        while (!bus.ARREADY && k < 50) begin @(negedge clk); #1; k++; end
        if (k == 50) timed_out("arready");
        @(negedge clk);
        bus.ARVALID = 1'b0;
    endtask

    task automatic w_phase(input vec_t v, input int tag);
        logic [3:0] ew;
        int k;
        ew = v.acc ? ~v.strb : 4'hF;
        for (int b = 0; b <= int'(v.len); b++) begin
            bus.WDATA = v.d[b];
            bus.WSTRB = v.strb;
            bus.WLAST = (b == int'(v.len)) != (b == int'(v.bad));
            bus.WVALID = 1'b1;
            #1;
            k = 0;
            while (!bus.WREADY && k < 50) begin @(negedge clk); #1; k++; end
            if (k == 50) timed_out($sformatf("v%0d wready", tag));
            check($sformatf("v%0d beat%0d ceb", tag, b), ceb, !v.acc);
            check($sformatf("v%0d beat%0d web", tag, b), web, ew);
            if (v.acc) check($sformatf("v%0d beat%0d di", tag, b), di, v.d[b]);
            if (v.acc && b == 0) check($sformatf("v%0d beat0 addr", tag), a, v.a0);
            @(negedge clk);
        end
        bus.WVALID = 1'b0;
        bus.WLAST = 1'b0;
    endtask

    task automatic b_phase(input vec_t v, input int tag);
        int k;
        k = 0;
        bus.BREADY = 1'b1;
        #1;
        while (!bus.BVALID && k < 50) begin @(negedge clk); #1; k++; end
        if (k == 50) timed_out($sformatf("v%0d bvalid", tag));
        else begin
            check($sformatf("v%0d bresp", tag), bus.BRESP, v.resp);
            check($sformatf("v%0d bid", tag), bus.BID, v.id);
        end
        @(negedge clk);
        bus.BREADY = 1'b0;
    endtask

    task automatic r_phase(input vec_t v, input int tag, input logic chk_lat);
        int k;
        int lat;
        lat = 1;
        bus.RREADY = 1'b1;
        for (int b = 0; b <= int'(v.len); b++) begin
            k = 0;
            while (!bus.RVALID && k < 50) begin @(negedge clk); k++; lat++; end
            if (k == 50) timed_out($sformatf("v%0d rvalid", tag));
            if (b == 0 && chk_lat) check($sformatf("v%0d rvalid latency", tag), lat, 2);
            check($sformatf("v%0d beat%0d rdata", tag, b), bus.RDATA, v.d[b]);
            check($sformatf("v%0d beat%0d rresp", tag, b), bus.RRESP, v.resp);
            check($sformatf("v%0d beat%0d rid", tag, b), bus.RID, v.id);
            check($sformatf("v%0d beat%0d rlast", tag, b), bus.RLAST, b == int'(v.len));
            @(negedge clk);
        end
        bus.RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vw, vr, v7;
        int k;
        logic granted_wr;
        logic [31:0] exp_wr;

        for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = '0;

        vecs[0]  = mk(1'b1, 8'h05, 32'h10, 4'd3, INCR, 4'hF, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00, 1'b1, 14'd4);
        vecs[1]  = mk(1'b0, 8'h06, 32'h10, 4'd3, INCR, 4'hF, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2'b00, 1'b1, 14'd4);
        vecs[2]  = mk(1'b1, 8'h01, 32'h40, 4'd0, INCR, 4'hF, 4'hF, 32'h12345678, 0, 0, 0, 2'b00, 1'b1, 14'd16);
        vecs[3]  = mk(1'b1, 8'h02, 32'h40, 4'd0, INCR, 4'h5, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 2'b00, 1'b1, 14'd16);
        vecs[4]  = mk(1'b0, 8'h03, 32'h40, 4'd0, INCR, 4'hF, 4'hF, 32'h12FF56FF, 0, 0, 0, 2'b00, 1'b1, 14'd16);
        vecs[5]  = mk(1'b1, 8'h04, 32'h80, 4'd2, FIXED, 4'hF, 4'hF, 32'h1, 32'h2, 32'h3, 0, 2'b00, 1'b1, 14'd32);
        vecs[6]  = mk(1'b0, 8'h07, 32'h80, 4'd1, FIXED, 4'hF, 4'hF, 32'h3, 32'h3, 0, 0, 2'b00, 1'b1, 14'd32);
        vecs[7]  = mk(1'b1, 8'h08, 32'h20, 4'd1, INCR, 4'hF, 4'd0, 32'hB0, 32'hB1, 0, 0, 2'b10, 1'b1, 14'd8);
        vecs[8]  = mk(1'b0, 8'h09, 32'h20, 4'd1, INCR, 4'hF, 4'hF, 32'hB0, 32'hB1, 0, 0, 2'b00, 1'b1, 14'd8);
        vecs[9]  = mk(1'b1, 8'h0A, 32'h30, 4'd1, RSVD, 4'hF, 4'hF, 32'hC0, 32'hC1, 0, 0, 2'b00, 1'b1, 14'd12);
        vecs[10] = mk(1'b0, 8'h0B, 32'h30, 4'd1, RSVD, 4'hF, 4'hF, 32'hC0, 32'hC1, 0, 0, 2'b00, 1'b1, 14'd12);
        vecs[11] = mk(1'b1, 8'h0C, 32'h10000, 4'd0, INCR, 4'hF, 4'hF, 32'hD0, 0, 0, 0, 2'b00, 1'b1, 14'd0);
        vecs[12] = mk(1'b0, 8'h0D, 32'h0, 4'd0, INCR, 4'hF, 4'hF, 32'hD0, 0, 0, 0, 2'b00, 1'b1, 14'd0);
`ifdef AXI_SRAM_WRAP_EN
        vecs[13] = mk(1'b0, 8'h0E, 32'h18, 4'd3, WRAP, 4'hF, 4'hF, 32'hA2, 32'hA3, 32'hA0, 32'hA1, 2'b00, 1'b1, 14'd6);
        vecs[14] = mk(1'b1, 8'h0F, 32'h100, 4'd1, WRAP, 4'hF, 4'hF, 32'hE0, 32'hE1, 0, 0, 2'b00, 1'b1, 14'd64);
        vecs[15] = mk(1'b0, 8'h10, 32'h100, 4'd1, INCR, 4'hF, 4'hF, 32'hE0, 32'hE1, 0, 0, 2'b00, 1'b1, 14'd64);
`else
        vecs[13] = mk(1'b0, 8'h0E, 32'h18, 4'd3, WRAP, 4'hF, 4'hF, 0, 0, 0, 0, 2'b10, 1'b0, 14'd6);
        vecs[14] = mk(1'b1, 8'h0F, 32'h100, 4'd1, WRAP, 4'hF, 4'hF, 32'hE0, 32'hE1, 0, 0, 2'b10, 1'b0, 14'd64);
        vecs[15] = mk(1'b0, 8'h10, 32'h100, 4'd1, INCR, 4'hF, 4'hF, 0, 0, 0, 0, 2'b00, 1'b1, 14'd64);
`endif

        bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
        bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
        bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst awready", bus.AWREADY, 0);
        check("rst arready", bus.ARREADY, 0);
        check("rst wready", bus.WREADY, 0);
        check("rst bvalid", bus.BVALID, 0);
        check("rst rvalid", bus.RVALID, 0);
        check("rst rlast", bus.RLAST, 0);
        check("rst rdata", bus.RDATA, 0);
        check("rst bid", bus.BID, 0);
        check("rst rid", bus.RID, 0);
        check("rst bresp", bus.BRESP, 0);
        check("rst rresp", bus.RRESP, 0);
        check("rst ceb", ceb, 1);
        check("rst web", web, 4'hF);
        check("rst a", a, 0);
        check("rst di", di, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].wr) begin
                aw_phase(vecs[i]);
                w_phase(vecs[i], i);
                b_phase(vecs[i], i);
            end else begin
                ar_phase(vecs[i]);
                r_phase(vecs[i], i, 1'b1);
            end
        end

        // both valids held across three transactions: expect write, read, write
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vw = mk(1'b1, 8'h21, 32'h200, 4'd0, INCR, 4'hF, 4'hF, 32'h55, 0, 0, 0, 2'b00, 1'b1, 14'd128);
        vr = mk(1'b0, 8'h22, 32'h200, 4'd0, INCR, 4'hF, 4'hF, 32'h55, 0, 0, 0, 2'b00, 1'b1, 14'd128);
        bus.AWID = vw.id; bus.AWADDR = vw.addr; bus.AWLEN = vw.len; bus.AWBURST = vw.burst;
        bus.ARID = vr.id; bus.ARADDR = vr.addr; bus.ARLEN = vr.len; bus.ARBURST = vr.burst;
        for (int t = 0; t < 3; t++) begin
            exp_wr = (t == 1) ? 32'd0 : 32'd1;
            bus.AWVALID = 1'b1;
            bus.ARVALID = 1'b1;
            #1;
            k = 0;
            while (!bus.AWREADY && !bus.ARREADY && k < 50) begin @(negedge clk); #1; k++; end
            if (k == 50) timed_out($sformatf("arb%0d grant", t));
            granted_wr = bus.AWREADY;
            check($sformatf("arb%0d awready", t), bus.AWREADY, exp_wr);
            check($sformatf("arb%0d arready", t), bus.ARREADY, !exp_wr[0]);
            @(negedge clk);
            if (granted_wr) begin
                bus.AWVALID = 1'b0;
                w_phase(vw, 100 + t);
                b_phase(vw, 100 + t);
            end else begin
                bus.ARVALID = 1'b0;
                r_phase(vr, 100 + t, 1'b1);
            end
        end
        bus.AWVALID = 1'b0;
        bus.ARVALID = 1'b0;

        // reset during beat 2 of an 8-beat read
        v7 = mk(1'b0, 8'h31, 32'h10, 4'd7, INCR, 4'hF, 4'hF, 0, 0, 0, 0, 2'b00, 1'b1, 14'd4);
        ar_phase(v7);
        bus.RREADY = 1'b1;
        k = 0;
        for (int beats = 0; beats < 2 && k < 50; k++) begin
            if (bus.RVALID) beats++;
            @(negedge clk);
        end
        while (!bus.RVALID && k < 50) begin @(negedge clk); k++; end
        if (k == 50) timed_out("midrst beat2 rvalid");
        check("midrst beat2 rlast", bus.RLAST, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst rvalid", bus.RVALID, 0);
        check("midrst rlast", bus.RLAST, 0);
        check("midrst ceb", ceb, 1);
        check("midrst rdata", bus.RDATA, 0);
        rst_n = 1'b1;
        bus.RREADY = 1'b0;
        @(negedge clk);
        check("midrst idle rvalid", bus.RVALID, 0);
        vr = mk(1'b0, 8'h32, 32'h14, 4'd0, INCR, 4'hF, 4'hF, 32'hA1, 0, 0, 0, 2'b00, 1'b1, 14'd5);
        ar_phase(vr);
        r_phase(vr, 200, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end
endmodule
